// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: oversampling ratio, frame width, byte type and FSM encoding.
// Pure declarations; no latency or backpressure.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    typedef logic [DATA_BITS-1:0] byte_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through byte FIFO; head visible the cycle after the write edge, 0x00 when empty.
// Backpressure: a push into a full FIFO is dropped unless a pop happens in the same cycle; pops while empty are ignored.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  logic  pop,
    input  byte_t din,
    output byte_t dout,
    output logic  empty,
    output logic  full
);

    localparam int AW = $clog2(DEPTH);

    byte_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a FWFT FIFO; byte visible 2 cycles after the stop-bit sample.
// Backpressure: none toward the line; a full FIFO drops the byte and raises sticky overrun unless rd_en pops that cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 54,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       fifo_full,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TW = $clog2(BAUD_DIV + 1);

    logic          rx_meta;
    logic          rx_s;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [2:0]    state;
    logic [3:0]    os_cnt;
    logic [2:0]    bit_cnt;
    byte_t         shreg;
    logic          push_req;
    logic          start_edge;
    logic          sample_pt;
    logic          frame_set;
    logic          overrun_set;
    logic          fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    assign start_edge = (state == ST_IDLE) && !rx_s;
    assign tick       = (tick_cnt == TW'(BAUD_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || start_edge || tick) tick_cnt <= '0;
        else                             tick_cnt <= tick_cnt + 1'b1;
    end

    // Start bit is checked mid-bit; each later bit is sampled a full bit period after that.
    assign sample_pt = tick && (os_cnt == ((state == ST_START) ? 4'(OVERSAMPLE/2 - 1)
                                                               : 4'(OVERSAMPLE - 1)));
    assign frame_set = (state == ST_STOP) && sample_pt && !rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            push_req <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (tick) os_cnt <= sample_pt ? 4'd0 : os_cnt + 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state   <= ST_START;
                        os_cnt  <= '0;
                        bit_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (sample_pt) state <= rx_s ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (sample_pt) begin
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'(DATA_BITS - 1)) state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (sample_pt) begin
                        push_req <= rx_s;
                        state    <= rx_s ? ST_IDLE : ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // When full the FIFO is non-empty, so rd_en alone decides whether the push fits.
    assign overrun_set = push_req && fifo_full && !rd_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_set   | (frame_err & ~clr_err);
            overrun   <= overrun_set | (overrun   & ~clr_err);
        end
    end

    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (rd_en),
        .din   (shreg),
        .dout  (rx_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at BAUD_DIV=4 (64 clk per bit).
// Stimulus queues expected bytes; a negedge monitor checks every accepted pop against the queue.
module tb_uart_rx_fifo;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_in = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       fifo_full;
    logic       frame_err;
    logic       overrun;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(.BAUD_DIV(4), .FIFO_DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_in),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .fifo_full (fifo_full),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: any pop the DUT accepts must match the oldest expected byte.
    always @(negedge clk) begin
        if (!reset && rd_en && rx_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected actual=0x%0h required=no_data", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("pop_data", 32'(rx_data), 32'(e));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx_in = 1'b0;
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            step(BIT);
        end
        rx_in = stop;
        step(BIT);
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        step(n);
        rd_en = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int cyc);
        cyc = 0;
        while (!rx_valid && cyc < max) begin
            step(1);
            cyc++;
        end
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        step(4);
        reset = 1'b0;
        step(2);
        check("rst_rx_valid",  32'(rx_valid),  0);
        check("rst_fifo_full", 32'(fifo_full), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_overrun",   32'(overrun),   0);
        check("rst_rx_data",   32'(rx_data),   0);

        // Single byte latency
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1);
            wait_valid(700, cyc);
        join
        check("t55_latency_ok", 32'(cyc <= 10*BIT + 8), 1);
        check("t55_rx_valid",   32'(rx_valid),  1);
        check("t55_frame_err",  32'(frame_err), 0);
        pop_n(1);

        // Short low glitch is rejected
        rx_in = 1'b0;
        step(16);
        rx_in = 1'b1;
        step(3*BIT);
        check("glitch_rx_valid",  32'(rx_valid),  0);
        check("glitch_frame_err", 32'(frame_err), 0);
        check("glitch_overrun",   32'(overrun),   0);

        // Framing error followed by a break
        send_frame(8'hA3, 1'b0);
        check("ferr_set",      32'(frame_err), 1);
        check("ferr_rx_valid", 32'(rx_valid),  0);
        pulse_clr();
        check("ferr_cleared",  32'(frame_err), 0);
        step(3*BIT - 1);
        rx_in = 1'b1;
        step(2*BIT);
        check("ferr_once",       32'(frame_err), 0);
        check("ferr_fifo_empty", 32'(rx_valid),  0);

        // Overflow: 17 bytes, no reads
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        check("ovf_fifo_full", 32'(fifo_full), 1);
        check("ovf_overrun",   32'(overrun),   1);
        pop_n(16);
        check("ovf_drained_valid", 32'(rx_valid),  0);
        check("ovf_drained_full",  32'(fifo_full), 0);
        pulse_clr();
        check("ovf_cleared", 32'(overrun), 0);

        // Push and pop in the same cycle while full
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(8'h20 + i));
            send_frame(8'(8'h20 + i), 1'b1);
        end
        check("sim_full_before", 32'(fifo_full), 1);
        exp_q.push_back(8'h30);
        fork
            send_frame(8'h30, 1'b1);
            begin
                step(611);
                rd_en = 1'b1;
                step(1);
                rd_en = 1'b0;
            end
        join
        check("sim_overrun",    32'(overrun),   0);
        check("sim_still_full", 32'(fifo_full), 1);
        pop_n(16);
        check("sim_drained", 32'(rx_valid), 0);

        // Reset in the middle of a frame
        send_frame(8'h77, 1'b1);
        check("mid_rst_pre_valid", 32'(rx_valid), 1);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                step(5*BIT + BIT/2);
                reset = 1'b1;
                step(2);
                reset = 1'b0;
                check("mid_rst_rx_valid",  32'(rx_valid),  0);
                check("mid_rst_fifo_full", 32'(fifo_full), 0);
                check("mid_rst_frame_err", 32'(frame_err), 0);
                check("mid_rst_overrun",   32'(overrun),   0);
                check("mid_rst_rx_data",   32'(rx_data),   0);
            end
        join
        step(BIT);
        check("mid_rst_no_push", 32'(rx_valid), 0);
        exp_q.push_back(8'h3C);
        fork
            send_frame(8'h3C, 1'b1);
            wait_valid(700, cyc);
        join
        check("post_rst_valid", 32'(rx_valid), 1);
        pop_n(1);
        check("post_rst_frame_err", 32'(frame_err), 0);
        check("post_rst_overrun",   32'(overrun),   0);

        step(2);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter BAUD_DIV, default 54, means clk cycles per 16x-oversample tick (100 MHz, 115200 baud).
REQ-002 Parameter FIFO_DEPTH, default 16, means receive FIFO entries (power of two, at least 2).
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port rx_in, input, 1 bit: asynchronous serial line (RsRx); idles high; 8N1 framing, LSB first.
REQ-006 Port rd_en, input, 1 bit: pop the FIFO head at the clock edge when rx_valid is 1.
REQ-007 Port clr_err, input, 1 bit: clears frame_err and overrun at the clock edge.
REQ-008 Port rx_data, output, 8 bits: FIFO head (first-word-fall-through); 0x00 when empty.
REQ-009 Port rx_valid, output, 1 bit: FIFO not empty.
REQ-010 Port fifo_full, output, 1 bit: FIFO holds FIFO_DEPTH bytes.
REQ-011 Port frame_err, output, 1 bit: sticky; a stop bit was sampled low.
REQ-012 Port overrun, output, 1 bit: sticky; a received byte was dropped because the FIFO was full.

Function
REQ-013 rx_in SHALL pass through a two-flop synchroniser; both flops reset to 1.
REQ-014 The tick counter SHALL count 0..BAUD_DIV-1, issue a one-cycle tick at BAUD_DIV-1, and reload to 0 when a start edge is detected.
REQ-015 The FSM SHALL have five states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-016 IDLE: when the synchronised line is 0, move to START and clear the tick and bit counters.
REQ-017 START: at the 8th tick, a sampled 0 moves to DATA; a sampled 1 is a glitch and returns to IDLE with no flag.
REQ-018 DATA: sample every 16th tick; shift LSB first; after 8 bits move to STOP.
REQ-019 STOP: at the 16th tick, a sampled 1 pushes the byte and moves to IDLE.
REQ-020 STOP: a sampled 0 sets frame_err, discards the byte, and moves to WAIT_HIGH.
REQ-021 WAIT_HIGH: move to IDLE only when the synchronised line is 1, so a break condition yields exactly one frame_err.
REQ-022 Push timing: the byte enters the FIFO at the edge after the stop sample; rx_valid rises one cycle later.
REQ-023 A push when the FIFO is full and rd_en is 0 SHALL drop the byte and set overrun; the FIFO contents stay unchanged.
REQ-024 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full; overrun is not set.
REQ-025 rd_en while the FIFO is empty SHALL be ignored; pointers are unchanged.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-027 If a set condition and clr_err occur in the same cycle, the flag SHALL be set (set wins).

Reset
REQ-028 Reset SHALL put the FSM in IDLE and clear the tick counter, bit counter, shift register, FIFO pointers and FIFO count.
REQ-029 Reset values: rx_valid=0, fifo_full=0, frame_err=0, overrun=0, rx_data=0x00.
REQ-030 Reset during a frame SHALL abandon the partial byte; the remaining bits of that frame SHALL NOT produce a push or a flag once the line returns high.

Structure
REQ-031 Shared package uart_pkg SHALL hold the FSM state encoding, OVERSAMPLE=16, DATA_BITS=8 and the 8-bit byte type.
REQ-032 FIFO storage and pointers SHALL live in one sub-module, sync_fifo (clk, reset, push, pop, din, dout, empty, full).
REQ-033 The synchroniser, tick counter and FSM SHALL reside in uart_rx_fifo.

Verification
REQ-034 Benches SHALL use BAUD_DIV=4 (64 clk per bit).
REQ-035 Send 0x55 -> rx_valid=1 with rx_data=0x55 by cycle 10*64+8 after the start edge; frame_err=0.
REQ-036 Drive rx_in low for 16 cycles, then high -> no push, rx_valid stays 0, no flags.
REQ-037 Send 0xA3 with stop bit 0, then hold the line low for 3 bit-times -> frame_err=1 exactly once, FIFO empty; clr_err clears it.
REQ-038 Send 17 bytes 0x00..0x10 with no reads -> fifo_full=1, overrun=1; 16 pops return 0x00..0x0F in order.
REQ-039 With the FIFO full, assert rd_en in the push cycle of the next byte -> overrun=0, count stays 16, and the last pop returns the new byte.
REQ-040 Assert reset at bit 4 of 0xFF -> all outputs at reset values; the next byte 0x3C is received correctly.
